// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the 68000 bus between the CPU and two internal masters.
// Runs the BR/BG/BGACK handshake. When both masters request at once, they are
// served round-robin. The bus goes back to the CPU when neither master needs it.
module bus_arbiter #(
  parameter int SYNC_STAGES   = 2,     // depth of the BG/AS synchronizers (min 2)
  parameter int GRANT_TIMEOUT = 1023   // MCLK cycles to wait for BG
) (
  input  logic       MCLK_IN,
  input  logic       RESET_n_IN,
  input  logic       BG_IN,
  input  logic       AS_IN,
  input  logic [1:0] REQ_IN,
  output logic       BR,
  output logic       BGACK,
  output logic [1:0] GNT,
  output logic       TIMEOUT
);

  localparam int          CNT_W       = 10;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(GRANT_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT_BUS,
    S_OWN,
    S_HANDOFF,
    S_RELEASE
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_sel;        // index of the master being served
  logic                   w_next_sel;
  logic                   r_last;       // last master served (round-robin pointer)
  logic                   w_next_last;
  logic [CNT_W-1:0]       r_cnt;        // cycles spent waiting for BG
  logic [SYNC_STAGES-1:0] r_bg_sync;
  logic [SYNC_STAGES-1:0] r_as_sync;
  logic                   r_as_low_prev; // AS_S was low on the previous cycle
  logic                   w_bg_s;
  logic                   w_as_s;
  logic                   w_winner;
  logic                   w_timeout;

  assign w_bg_s = r_bg_sync[SYNC_STAGES-1];
  assign w_as_s = r_as_sync[SYNC_STAGES-1];

  // Winner of IDLE arbitration: the lone requester, or on a tie the one not served last.
  assign w_winner = (REQ_IN == 2'b11) ? ~r_last : REQ_IN[1];

  // Bring the asynchronous CPU strobes into the MCLK domain.
  always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      r_bg_sync     <= '0;
      r_as_sync     <= '0;
      r_as_low_prev <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge, which makes the shift work.
      r_bg_sync     <= {r_bg_sync[SYNC_STAGES-2:0], BG_IN};
      r_as_sync     <= {r_as_sync[SYNC_STAGES-2:0], AS_IN};
      r_as_low_prev <= ~w_as_s;
    end
  end

  // State register, grant selection, round-robin pointer and BG wait counter.
  always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_sel   <= w_next_sel;
      r_last  <= w_next_last;
      // The counter runs only while the FSM stays in REQUEST. Everywhere else it
      // is held at zero, so it restarts from zero each time REQUEST is entered.
      if (r_state == S_REQUEST && w_next_state == S_REQUEST)
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;
    end
  end

  // Next-state logic. Outputs are decoded from the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves one unassigned and no latch is inferred.
    w_next_state = r_state;
    w_next_sel   = r_sel;
    w_next_last  = r_last;
    w_timeout    = 1'b0;
    BR           = 1'b0;
    BGACK        = 1'b0;
    GNT          = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (REQ_IN != 2'b00) begin
          w_next_sel   = w_winner;
          w_next_state = S_REQUEST;
        end
      end

      S_REQUEST: begin
        BR = 1'b1;
        if (w_bg_s) begin
          w_next_state = S_WAIT_BUS;
        end else if (!REQ_IN[r_sel]) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == TIMEOUT_CNT) begin
          // Give up on BG. Record this master as the last one served, so the
          // other master wins the next tie.
          w_timeout    = 1'b1;
          w_next_last  = r_sel;
          w_next_state = S_IDLE;
        end
      end

      S_WAIT_BUS: begin
        // The CPU cycle is over once AS_S has been low for two consecutive samples.
        // SEL stays fixed here, even if the requests change.
        BR = 1'b1;
        if (!w_as_s && r_as_low_prev)
          w_next_state = S_OWN;
      end

      S_OWN: begin
        BGACK = 1'b1;
        GNT   = r_sel ? 2'b10 : 2'b01;
        if (!REQ_IN[r_sel]) begin
          w_next_last  = r_sel;
          w_next_state = REQ_IN[~r_sel] ? S_HANDOFF : S_RELEASE;
        end
      end

      S_HANDOFF: begin
        // Keep BGACK high for one idle cycle and pass the bus to the other master.
        BGACK        = 1'b1;
        w_next_sel   = ~r_sel;
        w_next_state = S_OWN;
      end

      S_RELEASE: begin
        w_next_state = S_IDLE;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    TIMEOUT = w_timeout;
  end

endmodule
